// File: rtl/tx_pkg.sv
// Shared types and helpers for the UART word transmitter.
//   tx_state_t     : transmitter FSM state encoding
//   BYTES_PER_WORD : bytes in one readout word
//   find_byte()    : priority search for the lowest enabled byte at/above an index
package tx_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = BYTES_PER_WORD * BYTE_W;
  localparam int unsigned IDX_W          = 2;
  localparam int unsigned BIT_IDX_W      = 3;

  // Returns {found, index} of the lowest set mask bit whose index is >= from.
  // 'from' is one bit wider than an index so "past the last byte" is expressible.
  function automatic logic [IDX_W:0] find_byte(input logic [BYTES_PER_WORD-1:0] mask,
                                               input logic [IDX_W:0]            from);
    logic [IDX_W:0] res;
    res = '0;
    for (int k = BYTES_PER_WORD - 1; k >= 0; k--) begin
      if (mask[k] && ((IDX_W + 1)'(k) >= from)) begin
        res = {1'b1, IDX_W'(k)};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/transmitter_baud_gen.sv
// Bit-period timer for the UART transmitter.
//   clk_i  : system clock
//   rst_in : synchronous active-low reset
//   clr_i  : restart the bit period at count 0
//   tick_o : high during the last cycle of each bit period (registered)
module baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk_i,
  input  logic rst_in,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_next;

  // Wrap at the end of a period, or restart on request.
  always_comb begin
    cnt_next = cnt_q + CNT_W'(1);
    if (clr_i || (cnt_q == LAST)) begin
      cnt_next = '0;
    end
  end

  // tick is registered from the next count so it lines up with cnt_q == LAST.
  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      cnt_q  <= '0;
      tick_o <= 1'b0;
    end else begin
      cnt_q  <= cnt_next;
      tick_o <= (cnt_next == LAST);
    end
  end

endmodule

// File: rtl/transmitter.sv
// Serialises the enabled bytes of a 32-bit readout word as 8N1 UART frames,
// byte 0 first; disabled byte groups are skipped.
//   clk_i    : system clock
//   rst_in   : synchronous active-low reset
//   stb_i    : word strobe, accepted only while rdy_o = 1
//   data_i   : word to send, byte k = data_i[8k+7:8k]
//   grp_en_i : byte enable mask, bit k enables byte k
//   rdy_o    : idle, able to accept a word
//   tx_o     : serial line, idle high
module transmitter
  import tx_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 115_200
) (
  input  logic        clk_i,
  input  logic        rst_in,
  input  logic        stb_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  grp_en_i,
  output logic        rdy_o,
  output logic        tx_o
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("transmitter: CLK_FREQ/BAUD must be at least 2");
  end

  tx_state_t                   state_q;
  tx_state_t                   state_next;
  logic [WORD_W-1:0]           data_q;
  logic [BYTES_PER_WORD-1:0]   mask_q;
  logic [IDX_W-1:0]            byte_idx_q;
  logic [IDX_W-1:0]            byte_idx_next;
  logic [BIT_IDX_W-1:0]        bit_idx_q;
  logic [BIT_IDX_W-1:0]        bit_idx_next;
  logic [BYTE_W-1:0]           shreg_q;
  logic [BYTE_W-1:0]           shreg_next;
  logic                        tx_next;
  logic                        tick;
  logic                        clr_c;
  logic                        accept_c;
  logic [IDX_W:0]              first_c;
  logic [IDX_W:0]              above_c;

  baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_gen (
    .clk_i  (clk_i),
    .rst_in (rst_in),
    .clr_i  (clr_c),
    .tick_o (tick)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  // Next-state, datapath updates and line level.
  always_comb begin
    state_next    = state_q;
    byte_idx_next = byte_idx_q;
    bit_idx_next  = bit_idx_q;
    shreg_next    = shreg_q;
    tx_next       = 1'b1;
    accept_c      = 1'b0;
    first_c       = find_byte(grp_en_i, '0);
    above_c       = find_byte(mask_q, {1'b0, byte_idx_q} + (IDX_W + 1)'(1));

    unique case (state_q)
      IDLE: begin
        if (stb_i) begin
          accept_c = 1'b1;
          if (first_c[IDX_W]) begin
            state_next    = START;
            byte_idx_next = first_c[IDX_W-1:0];
          end else begin
            // Empty mask: one busy cycle through STOP, nothing on the line.
            state_next = STOP;
          end
        end
      end
      START: begin
        tx_next = 1'b0;
        if (tick) begin
          state_next   = DATA;
          bit_idx_next = '0;
          shreg_next   = data_q[{byte_idx_q, 3'b000} +: BYTE_W];
        end
      end
      DATA: begin
        tx_next = shreg_q[0];
        if (tick) begin
          shreg_next = shreg_q >> 1;
          if (bit_idx_q == BIT_IDX_W'(BYTE_W - 1)) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx_q + BIT_IDX_W'(1);
          end
        end
      end
      STOP: begin
        if (mask_q == '0) begin
          state_next = IDLE;
        end else if (tick) begin
          if (above_c[IDX_W]) begin
            state_next    = START;
            byte_idx_next = above_c[IDX_W-1:0];
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Every state change restarts the bit period.
    clr_c = (state_next != state_q);
  end

  // Datapath and output flops; tx_o trails the state by one cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      data_q     <= '0;
      mask_q     <= '0;
      byte_idx_q <= '0;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      tx_o       <= 1'b1;
      rdy_o      <= 1'b1;
    end else begin
      if (accept_c) begin
        data_q <= data_i;
        mask_q <= grp_en_i;
      end
      byte_idx_q <= byte_idx_next;
      bit_idx_q  <= bit_idx_next;
      shreg_q    <= shreg_next;
      tx_o       <= tx_next;
      rdy_o      <= (state_next == IDLE);
    end
  end

endmodule

// File: tb/tb_transmitter.sv
// Scoreboard bench for transmitter: stimulus pushes expected bytes, a UART
// monitor decodes tx and compares each completed frame.
module tb_transmitter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stb;
  logic [31:0] data;
  logic [3:0]  mask;
  logic        rdy;
  logic        tx;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          frames   = 0;
  logic [7:0]  exp_q[$];
  int          starts_q[$];
  logic        mon_flush = 1'b1;

  transmitter #(
    .CLK_FREQ (400),
    .BAUD     (100)
  ) dut (
    .clk_i    (clk),
    .rst_in   (rst_n),
    .stb_i    (stb),
    .data_i   (data),
    .grp_en_i (mask),
    .rdy_o    (rdy),
    .tx_o     (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // UART monitor: 4 clocks per bit, samples in the middle of each bit.
  initial begin : monitor
    bit   in_frame;
    int   pos;
    logic [7:0] acc;
    in_frame = 1'b0;
    pos = 0;
    acc = '0;
    forever begin
      @(negedge clk);
      if (mon_flush) begin
        in_frame = 1'b0;
      end else if (!in_frame) begin
        if (tx === 1'b0) begin
          in_frame = 1'b1;
          pos      = 0;
          acc      = '0;
          starts_q.push_back(cyc);
        end
      end else begin
        pos++;
        if (pos == 2) begin
          check("start_bit", 32'(tx), 32'd0);
        end else if (pos >= 6 && pos <= 34 && ((pos - 6) % 4) == 0) begin
          acc[3'((pos - 6) / 4)] = tx;
        end else if (pos == 38) begin
          check("stop_bit", 32'(tx), 32'd1);
          frames++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_frame actual=%02h required=no frame (cycle %0d)", acc, cyc);
          end else begin
            check("frame_byte", 32'(acc), 32'(exp_q.pop_front()));
          end
          in_frame = 1'b0;
        end
      end
    end
  end

  // Drive one strobe from the current negedge; returns at the negedge after the sampling edge.
  task automatic strobe(input logic [31:0] d, input logic [3:0] m, input bit push);
    stb  = 1'b1;
    data = d;
    mask = m;
    if (push) begin
      for (int k = 0; k < 4; k++) begin
        if (m[k]) exp_q.push_back(d[8*k +: 8]);
      end
    end
    @(negedge clk);
    stb  = 1'b0;
  endtask

  // Count negedges with rdy low; optionally pulse a stray strobe at busy == pulse_at.
  task automatic wait_idle(input int pulse_at, output int busy);
    busy = 0;
    while (!rdy && busy < 2000) begin
      if (busy == pulse_at) begin
        stb  = 1'b1;
        data = 32'hDEADBEEF;
        mask = 4'hF;
      end else if (busy == pulse_at + 1) begin
        stb  = 1'b0;
        data = 32'h0;
        mask = 4'h0;
      end
      busy++;
      @(negedge clk);
    end
    stb = 1'b0;
    if (busy >= 2000) begin
      checks++;
      failures++;
      $display("FAIL wait_idle_timeout actual=busy required=idle within 2000 cycles");
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int busy;
    int bad;
    int f0;
    rst_n = 1'b0;
    stb   = 1'b0;
    data  = '0;
    mask  = '0;
    repeat (3) @(negedge clk);
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_rdy", 32'(rdy), 32'd1);
    rst_n = 1'b1;
    mon_flush = 1'b0;

    // 1: idle line after reset
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || rdy !== 1'b1) bad++;
    end
    check("idle_100", 32'(bad), 32'd0);

    // 2: full word, latency and busy time
    strobe(32'h44332211, 4'hF, 1'b1);
    check("latency_edge_n_tx", 32'(tx), 32'd1);
    check("rdy_drop", 32'(rdy), 32'd0);
    @(negedge clk);
    check("latency_edge_n1_tx", 32'(tx), 32'd0);
    wait_idle(-10, busy);
    check("busy_full", 32'(busy + 1), 32'd160);
    check("drained_full", 32'(exp_q.size()), 32'd0);

    // 3: sparse mask with no inter-frame gap, then a back-to-back word
    repeat (5) @(negedge clk);
    starts_q.delete();
    strobe(32'h44332211, 4'b0101, 1'b1);
    wait_idle(-10, busy);
    check("busy_sparse", 32'(busy), 32'd80);
    check("sparse_frames", 32'(starts_q.size()), 32'd2);
    if (starts_q.size() == 2) check("sparse_gap", 32'(starts_q[1] - starts_q[0]), 32'd40);
    strobe(32'h00007E00, 4'b0010, 1'b1);
    wait_idle(-10, busy);
    check("busy_b2b", 32'(busy), 32'd40);
    check("b2b_frames", 32'(starts_q.size()), 32'd3);
    if (starts_q.size() == 3) check("b2b_gap", 32'(starts_q[2] - starts_q[1]), 32'd41);
    check("drained_sparse", 32'(exp_q.size()), 32'd0);

    // 4: empty mask
    repeat (5) @(negedge clk);
    strobe(32'h12345678, 4'h0, 1'b1);
    wait_idle(-10, busy);
    check("busy_empty", 32'(busy), 32'd1);
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    check("empty_tx_low", 32'(bad), 32'd0);

    // 5: strobe while busy is ignored
    f0 = frames;
    strobe(32'h44332211, 4'hF, 1'b1);
    wait_idle(19, busy);
    check("busy_ignored", 32'(busy), 32'd160);
    repeat (60) @(negedge clk);
    check("ignored_frames", 32'(frames - f0), 32'd4);
    check("drained_ignored", 32'(exp_q.size()), 32'd0);

    // 6: reset during DATA bit 3, then a clean word
    strobe(32'h44332211, 4'hF, 1'b0);
    repeat (17) @(negedge clk);
    mon_flush = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_tx", 32'(tx), 32'd1);
    check("abort_rdy", 32'(rdy), 32'd1);
    @(negedge clk);
    mon_flush = 1'b0;
    strobe(32'h000000A5, 4'h1, 1'b1);
    wait_idle(-10, busy);
    check("busy_after_abort", 32'(busy), 32'd40);
    repeat (50) @(negedge clk);
    check("drained_final", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
